mux2_top: RTL and testbench



---
 rtl/mux2_top.sv | 56 +++++
 tb/tb_mux2_top.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux2_top.sv
// Registered two-way arithmetic select: out is either (a*b) or (a+b), both
// truncated to WIDTH bits, captured one clock after the operands are sampled.
module mux2_top #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] pp [WIDTH];
  logic [WIDTH-1:0] prod_d;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Partial product gi is a shifted left by gi; bits shifted past WIDTH drop out.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign pp[gi] = b[gi] ? (a << gi) : '0;
    end
  endgenerate

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      prod_d = prod_d + pp[i];
    end
  end

  assign sum_d = a + b;

  // Only a clean 1 selects the sum, so an X/Z select still yields the product.
  always_comb begin
    out_d = prod_d;
    case (sel)
      1'b1:    out_d = sum_d;
      default: out_d = prod_d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mux2_top.sv
// Self-checking bench for mux2_top: directed boundary cases, exhaustive
// product sweep and randomized mixed traffic against an arithmetic model.
module tb_mux2_top;

  localparam int WIDTH = 6;
  localparam int MOD   = 1 << WIDTH;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic [WIDTH-1:0] out;

  int pass_cnt;
  int total_cnt;

  mux2_top #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sel (sel),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input int av, input int bv, input bit use_sum);
    int r;
    r = use_sum ? (av + bv) % MOD : (av * bv) % MOD;
    return r[WIDTH-1:0];
  endfunction

  task automatic drive(input int av, input int bv, input logic s);
    @(negedge clk);
    a   = av[WIDTH-1:0];
    b   = bv[WIDTH-1:0];
    sel = s;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a   = 6'd5;
    b   = 6'd7;
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      total_cnt++;
      if (out !== '0) $display("FAIL reset_hold cycle %0d: out=%0d expected=0", i, out);
      else pass_cnt++;
      $display("reset_hold cycle %0d out=%0d", i, out);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    total_cnt++;
    if (out !== 6'd35) $display("FAIL reset_release: out=%0d expected=35", out);
    else pass_cnt++;
    $display("reset_release a=5 b=7 out=%0d", out);
  endtask

  task automatic test_product_exhaustive();
    int errs;
    errs = 0;
    for (int ai = 0; ai < MOD; ai++) begin
      for (int bi = 0; bi < MOD; bi++) begin
        logic [WIDTH-1:0] exp_v;
        drive(ai, bi, 1'b0);
        exp_v = model(ai, bi, 1'b0);
        edge_sample();
        total_cnt++;
        if (out !== exp_v) begin
          errs++;
          if (errs <= 10) $display("FAIL product a=%0d b=%0d: out=%0d expected=%0d", ai, bi, out, exp_v);
        end else begin
          pass_cnt++;
        end
      end
    end
    $display("product_exhaustive pairs=%0d errors=%0d", MOD * MOD, errs);
  endtask

  task automatic test_spot();
    int av [3] = '{7, 8, 63};
    int bv [3] = '{9, 8, 63};
    int ev [3] = '{63, 0, 1};
    for (int i = 0; i < 3; i++) begin
      drive(av[i], bv[i], 1'b0);
      edge_sample();
      total_cnt++;
      if (out !== ev[i][WIDTH-1:0]) $display("FAIL spot %0d*%0d: out=%0d expected=%0d", av[i], bv[i], out, ev[i]);
      else pass_cnt++;
      $display("spot %0d*%0d out=%0d", av[i], bv[i], out);
    end
  endtask

  task automatic test_sel_unknown();
    logic sv [2];
    sv[0] = 1'bz;
    sv[1] = 1'bx;
    for (int i = 0; i < 2; i++) begin
      drive(3, 5, sv[i]);
      edge_sample();
      total_cnt++;
      if (out !== 6'd15) $display("FAIL sel_unknown %0d: out=%b expected=15", i, out);
      else pass_cnt++;
      $display("sel_unknown case %0d a=3 b=5 out=%0d", i, out);
    end
  endtask

  task automatic test_sum();
    drive(20, 22, 1'b1);
    edge_sample();
    total_cnt++;
    if (out !== 6'd42) $display("FAIL sum_20_22: out=%0d expected=42", out);
    else pass_cnt++;
    $display("sum a=20 b=22 out=%0d", out);
    drive(63, 63, 1'b1);
    edge_sample();
    total_cnt++;
    if (out !== 6'd62) $display("FAIL sum_wrap: out=%0d expected=62", out);
    else pass_cnt++;
    $display("sum a=63 b=63 out=%0d", out);
    drive(63, 63, 1'b0);
    edge_sample();
    total_cnt++;
    if (out !== 6'd1) $display("FAIL sel_toggle_prod: out=%0d expected=1", out);
    else pass_cnt++;
    $display("prod a=63 b=63 out=%0d", out);
  endtask

  task automatic test_latency();
    drive(2, 4, 1'b0);
    edge_sample();
    total_cnt++;
    if (out !== 6'd8) $display("FAIL latency_first: out=%0d expected=8", out);
    else pass_cnt++;
    @(negedge clk);
    a = 6'd3;
    #1;
    total_cnt++;
    if (out !== 6'd8) $display("FAIL latency_hold: out=%0d expected=8", out);
    else pass_cnt++;
    $display("latency mid-cycle a=3 out=%0d", out);
    edge_sample();
    total_cnt++;
    if (out !== 6'd12) $display("FAIL latency_capture: out=%0d expected=12", out);
    else pass_cnt++;
    $display("latency after edge out=%0d", out);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out !== '0) $display("FAIL async_reset_immediate: out=%0d expected=0", out);
    else pass_cnt++;
    $display("async_reset mid-cycle out=%0d", out);
    edge_sample();
    total_cnt++;
    if (out !== '0) $display("FAIL async_reset_edge_blocked: out=%0d expected=0", out);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    total_cnt++;
    if (out !== 6'd12) $display("FAIL async_reset_resume: out=%0d expected=12", out);
    else pass_cnt++;
    $display("async_reset resume out=%0d", out);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      int av, bv;
      bit s;
      logic [WIDTH-1:0] exp_v;
      av = $urandom_range(MOD - 1, 0);
      bv = $urandom_range(MOD - 1, 0);
      s  = 1'($urandom_range(1, 0));
      drive(av, bv, s);
      exp_v = model(av, bv, s);
      edge_sample();
      total_cnt++;
      if (out !== exp_v) $display("FAIL random %0d a=%0d b=%0d sel=%0d: out=%0d expected=%0d", i, av, bv, s, out, exp_v);
      else pass_cnt++;
      $display("random %0d a=%0d b=%0d sel=%0d out=%0d", i, av, bv, s, out);
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    sel = 1'b0;
    test_reset();
    test_product_exhaustive();
    test_spot();
    test_sel_unknown();
    test_sum();
    test_latency();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
